// File: rtl/pic8259_pkg.sv
// Shared definitions for the 8259 command path: sequencer states and
// bit positions inside the ICW1, ICW4 and OCW3 command bytes.
package pic8259_pkg;

  typedef enum logic [1:0] {
    CMD_READY = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } cmd_state_t;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam int ICW1_ADI  = 2;
  localparam int ICW1_LTIM = 3;

  localparam int ICW4_UPM  = 0;
  localparam int ICW4_AEOI = 1;
  localparam int ICW4_MS   = 2;
  localparam int ICW4_BUF  = 3;
  localparam int ICW4_SFNM = 4;

  localparam int OCW3_RIS  = 0;
  localparam int OCW3_RR   = 1;
  localparam int OCW3_P    = 2;
  localparam int OCW3_SMM  = 5;
  localparam int OCW3_ESMM = 6;

endpackage

// File: rtl/icw_init_sequencer.sv
// ICW1..ICW4 initialization sequencer plus OCW1/OCW3 handling; holds the
// configuration registers consumed by the rest of the interrupt controller.
module icw_init_sequencer
  import pic8259_pkg::*;
#(
  parameter logic [7:0] MASK_RESET_VALUE = 8'h00,
  parameter bit         FORCE_ICW4       = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] internal_data_bus,
  input  logic       write_initial_command_word_1,
  input  logic       write_initial_command_word_2_4,
  input  logic       write_operation_control_word_1,
  input  logic       write_operation_control_word_3,
  output logic       level_or_edge_triggered,
  output logic       single_or_cascade,
  output logic       call_address_interval_4,
  output logic [4:0] interrupt_vector_base,
  output logic [7:0] cascade_config,
  output logic       u8086_or_mcs80,
  output logic       auto_eoi,
  output logic       buffered_mode,
  output logic       buffered_master,
  output logic       special_fully_nested,
  output logic [7:0] interrupt_mask,
  output logic       special_mask_mode,
  output logic       read_register_isr,
  output logic       poll_command,
  output logic       icw1_reset,
  output logic       init_done
);

  cmd_state_t state_q;
  cmd_state_t state_d;
  logic       ic4_q;
  logic       need_icw4;
  logic       icw1_acc;
  logic       icw2_acc;
  logic       icw3_acc;
  logic       icw4_acc;
  logic       ocw1_acc;
  logic       ocw3_acc;
  logic       enter_ready;

  assign need_icw4 = ic4_q | FORCE_ICW4;

  // Next-state and strobe qualification; ICW1 overrides every other strobe
  always_comb begin
    state_d  = state_q;
    icw1_acc = 1'b0;
    icw2_acc = 1'b0;
    icw3_acc = 1'b0;
    icw4_acc = 1'b0;
    ocw1_acc = 1'b0;
    ocw3_acc = 1'b0;
    if (write_initial_command_word_1) begin
      icw1_acc = 1'b1;
      state_d  = WAIT_ICW2;
    end else begin
      case (state_q)
        CMD_READY: begin
          ocw1_acc = write_operation_control_word_1;
          ocw3_acc = write_operation_control_word_3;
        end
        WAIT_ICW2: begin
          if (write_initial_command_word_2_4) begin
            icw2_acc = 1'b1;
            if (!single_or_cascade) state_d = WAIT_ICW3;
            else if (need_icw4)     state_d = WAIT_ICW4;
            else                    state_d = CMD_READY;
          end
        end
        WAIT_ICW3: begin
          if (write_initial_command_word_2_4) begin
            icw3_acc = 1'b1;
            state_d  = need_icw4 ? WAIT_ICW4 : CMD_READY;
          end
        end
        WAIT_ICW4: begin
          if (write_initial_command_word_2_4) begin
            icw4_acc = 1'b1;
            state_d  = CMD_READY;
          end
        end
        default: state_d = CMD_READY;
      endcase
    end
    enter_ready = (state_q != CMD_READY) && (state_d == CMD_READY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= CMD_READY;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_or_edge_triggered <= 1'b0;
      single_or_cascade       <= 1'b0;
      call_address_interval_4 <= 1'b0;
      ic4_q                   <= 1'b0;
      interrupt_vector_base   <= 5'd0;
      cascade_config          <= 8'd0;
      u8086_or_mcs80          <= 1'b0;
      auto_eoi                <= 1'b0;
      buffered_mode           <= 1'b0;
      buffered_master         <= 1'b0;
      special_fully_nested    <= 1'b0;
      interrupt_mask          <= MASK_RESET_VALUE;
      special_mask_mode       <= 1'b0;
      read_register_isr       <= 1'b0;
      poll_command            <= 1'b0;
      icw1_reset              <= 1'b0;
      init_done               <= 1'b0;
    end else begin
      icw1_reset   <= icw1_acc;
      poll_command <= ocw3_acc & internal_data_bus[OCW3_P];

      if (icw1_acc) begin
        level_or_edge_triggered <= internal_data_bus[ICW1_LTIM];
        single_or_cascade       <= internal_data_bus[ICW1_SNGL];
        call_address_interval_4 <= internal_data_bus[ICW1_ADI];
        ic4_q                   <= internal_data_bus[ICW1_IC4];
        interrupt_mask          <= MASK_RESET_VALUE;
        special_mask_mode       <= 1'b0;
        read_register_isr       <= 1'b0;
        u8086_or_mcs80          <= 1'b0;
        auto_eoi                <= 1'b0;
        buffered_mode           <= 1'b0;
        buffered_master         <= 1'b0;
        special_fully_nested    <= 1'b0;
        init_done               <= 1'b0;
      end

      if (icw2_acc) interrupt_vector_base <= internal_data_bus[7:3];
      if (icw3_acc) cascade_config        <= internal_data_bus;

      if (icw4_acc) begin
        u8086_or_mcs80       <= internal_data_bus[ICW4_UPM];
        auto_eoi             <= internal_data_bus[ICW4_AEOI];
        buffered_master      <= internal_data_bus[ICW4_MS];
        buffered_mode        <= internal_data_bus[ICW4_BUF];
        special_fully_nested <= internal_data_bus[ICW4_SFNM];
      end

      if (enter_ready) init_done <= 1'b1;

      if (ocw1_acc) interrupt_mask <= internal_data_bus;

      // ESMM and RR act as write enables for their companion bits
      if (ocw3_acc) begin
        if (internal_data_bus[OCW3_ESMM]) special_mask_mode <= internal_data_bus[OCW3_SMM];
        if (internal_data_bus[OCW3_RR])   read_register_isr <= internal_data_bus[OCW3_RIS];
      end
    end
  end

endmodule

// File: tb/tb_icw_init_sequencer.sv
// Directed and randomized bench for icw_init_sequencer against a
// write-queue model of the initialization sequence.
module tb_icw_init_sequencer;

  localparam logic [7:0] MRV   = 8'h00;
  localparam bit         FORCE = 1'b0;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic       write_initial_command_word_1 = 1'b0;
  logic       write_initial_command_word_2_4 = 1'b0;
  logic       write_operation_control_word_1 = 1'b0;
  logic       write_operation_control_word_3 = 1'b0;
  logic       level_or_edge_triggered;
  logic       single_or_cascade;
  logic       call_address_interval_4;
  logic [4:0] interrupt_vector_base;
  logic [7:0] cascade_config;
  logic       u8086_or_mcs80;
  logic       auto_eoi;
  logic       buffered_mode;
  logic       buffered_master;
  logic       special_fully_nested;
  logic [7:0] interrupt_mask;
  logic       special_mask_mode;
  logic       read_register_isr;
  logic       poll_command;
  logic       icw1_reset;
  logic       init_done;

  icw_init_sequencer #(
    .MASK_RESET_VALUE(MRV),
    .FORCE_ICW4      (FORCE)
  ) dut (
    .clock                          (clock),
    .reset_n                        (reset_n),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (write_initial_command_word_1),
    .write_initial_command_word_2_4 (write_initial_command_word_2_4),
    .write_operation_control_word_1 (write_operation_control_word_1),
    .write_operation_control_word_3 (write_operation_control_word_3),
    .level_or_edge_triggered        (level_or_edge_triggered),
    .single_or_cascade              (single_or_cascade),
    .call_address_interval_4        (call_address_interval_4),
    .interrupt_vector_base          (interrupt_vector_base),
    .cascade_config                 (cascade_config),
    .u8086_or_mcs80                 (u8086_or_mcs80),
    .auto_eoi                       (auto_eoi),
    .buffered_mode                  (buffered_mode),
    .buffered_master                (buffered_master),
    .special_fully_nested           (special_fully_nested),
    .interrupt_mask                 (interrupt_mask),
    .special_mask_mode              (special_mask_mode),
    .read_register_isr              (read_register_isr),
    .poll_command                   (poll_command),
    .icw1_reset                     (icw1_reset),
    .init_done                      (init_done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the ICW bytes still owed are kept as a queue of ICW numbers
  logic       m_ltim, m_sngl, m_adi;
  logic [4:0] m_vec;
  logic [7:0] m_casc;
  logic [4:0] m_icw4;
  logic [7:0] m_mask;
  logic       m_smm, m_ris, m_poll, m_icw1r, m_done;
  int         pend[$];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ltim = 0; m_sngl = 0; m_adi = 0; m_vec = 0; m_casc = 0; m_icw4 = 0;
    m_mask = MRV; m_smm = 0; m_ris = 0; m_poll = 0; m_icw1r = 0; m_done = 0;
    pend.delete();
  endtask

  task automatic model_apply(input bit icw1, input bit a0, input bit ocw3, input logic [7:0] d);
    bit ready;
    int k;
    m_poll  = 0;
    m_icw1r = 0;
    ready   = (pend.size() == 0);
    if (icw1) begin
      m_ltim = d[3]; m_sngl = d[1]; m_adi = d[2];
      pend.delete();
      pend.push_back(2);
      if (!d[1]) pend.push_back(3);
      if (d[0] || FORCE) pend.push_back(4);
      m_mask = MRV; m_smm = 0; m_ris = 0; m_icw4 = 0; m_done = 0; m_icw1r = 1;
    end else begin
      if (a0) begin
        if (!ready) begin
          k = pend.pop_front();
          if (k == 2) m_vec = d[7:3];
          else if (k == 3) m_casc = d;
          else m_icw4 = d[4:0];
          if (pend.size() == 0) m_done = 1;
        end else begin
          m_mask = d;
        end
      end
      if (ocw3 && ready) begin
        if (d[6]) m_smm = d[5];
        if (d[1]) m_ris = d[0];
        m_poll = d[2];
      end
    end
  endtask

  task automatic check_all(input string ph);
    check_eq({ph, ".ltim"},  level_or_edge_triggered, m_ltim);
    check_eq({ph, ".sngl"},  single_or_cascade, m_sngl);
    check_eq({ph, ".adi"},   call_address_interval_4, m_adi);
    check_eq({ph, ".vec"},   interrupt_vector_base, m_vec);
    check_eq({ph, ".casc"},  cascade_config, m_casc);
    check_eq({ph, ".upm"},   u8086_or_mcs80, m_icw4[0]);
    check_eq({ph, ".aeoi"},  auto_eoi, m_icw4[1]);
    check_eq({ph, ".ms"},    buffered_master, m_icw4[2]);
    check_eq({ph, ".buf"},   buffered_mode, m_icw4[3]);
    check_eq({ph, ".sfnm"},  special_fully_nested, m_icw4[4]);
    check_eq({ph, ".mask"},  interrupt_mask, m_mask);
    check_eq({ph, ".smm"},   special_mask_mode, m_smm);
    check_eq({ph, ".ris"},   read_register_isr, m_ris);
    check_eq({ph, ".poll"},  poll_command, m_poll);
    check_eq({ph, ".icw1r"}, icw1_reset, m_icw1r);
    check_eq({ph, ".done"},  init_done, m_done);
  endtask

  task automatic do_cycle(input string ph, input bit icw1, input bit a0, input bit ocw3,
                          input logic [7:0] d);
    @(negedge clock);
    internal_data_bus              = d;
    write_initial_command_word_1   = icw1;
    write_initial_command_word_2_4 = a0;
    write_operation_control_word_1 = a0;
    write_operation_control_word_3 = ocw3;
    @(posedge clock);
    #1;
    model_apply(icw1, a0, ocw3, d);
    write_initial_command_word_1   = 1'b0;
    write_initial_command_word_2_4 = 1'b0;
    write_operation_control_word_1 = 1'b0;
    write_operation_control_word_3 = 1'b0;
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(ph);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int op;
    logic [7:0] d;
    model_reset();
    #2;
    check_all("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // 1: single, ICW4 needed
    do_cycle("t1a", 1, 0, 0, 8'h13);
    do_cycle("t1b", 0, 1, 0, 8'h20);
    check_eq("t1_done_mid", init_done, 1'b0);
    do_cycle("t1c", 0, 1, 0, 8'h03);
    check_eq("t1_vec", interrupt_vector_base, 8'h04);
    check_eq("t1_aeoi", auto_eoi, 1'b1);
    check_eq("t1_upm", u8086_or_mcs80, 1'b1);
    check_eq("t1_done", init_done, 1'b1);
    check_eq("t1_casc", cascade_config, 8'h00);

    // 2: cascade, no ICW4
    do_cycle("t2a", 1, 0, 0, 8'h10);
    do_cycle("t2b", 0, 1, 0, 8'h08);
    do_cycle("t2c", 0, 1, 0, 8'h04);
    check_eq("t2_casc", cascade_config, 8'h04);
    check_eq("t2_done", init_done, 1'b1);

    // 3: OCW1 then ICW1 restarts
    do_cycle("t3a", 0, 1, 0, 8'hA5);
    check_eq("t3_mask", interrupt_mask, 8'hA5);
    check_eq("t3_vec", interrupt_vector_base, 8'h01);
    do_cycle("t3b", 1, 0, 0, 8'h13);
    check_eq("t3_mask0", interrupt_mask, 8'h00);
    check_eq("t3_icw1r", icw1_reset, 1'b1);
    check_eq("t3_done", init_done, 1'b0);
    do_cycle("t3c", 0, 0, 0, 8'h00);
    check_eq("t3_icw1r_off", icw1_reset, 1'b0);

    // 4: ICW1 from WAIT_ICW3, then ICW1 with simultaneous OCW3
    do_cycle("t4a", 1, 0, 0, 8'h10);
    do_cycle("t4b", 0, 1, 0, 8'h50);
    do_cycle("t4c", 1, 0, 0, 8'h10);
    check_eq("t4_casc", cascade_config, 8'h04);
    do_cycle("t4d", 0, 1, 0, 8'h60);
    do_cycle("t4e", 0, 1, 0, 8'h0F);
    check_eq("t4_casc2", cascade_config, 8'h0F);
    do_cycle("t4f", 1, 0, 1, 8'h1E);
    check_eq("t4_poll", poll_command, 1'b0);

    // 5: OCW3 decode and ignored during init
    do_cycle("t5a", 0, 1, 0, 8'h00);
    do_cycle("t5b", 0, 0, 1, 8'h6B);
    check_eq("t5_smm", special_mask_mode, 1'b1);
    check_eq("t5_ris", read_register_isr, 1'b1);
    do_cycle("t5c", 0, 0, 1, 8'h0C);
    check_eq("t5_poll", poll_command, 1'b1);
    do_cycle("t5d", 0, 0, 0, 8'h00);
    check_eq("t5_poll_off", poll_command, 1'b0);
    do_cycle("t5e", 1, 0, 0, 8'h12);
    do_cycle("t5f", 0, 0, 1, 8'h6F);
    check_eq("t5_smm_init", special_mask_mode, 1'b0);

    // 6: reset in WAIT_ICW4
    do_cycle("t6a", 1, 0, 0, 8'h1B);
    do_cycle("t6b", 0, 1, 0, 8'hF8);
    do_reset("t6rst");
    do_cycle("t6c", 0, 1, 0, 8'h3C);
    check_eq("t6_mask", interrupt_mask, 8'h3C);
    check_eq("t6_done", init_done, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 99);
      if (op < 30) begin
        do_cycle("rnd_idle", 0, 0, 0, 8'($urandom));
      end else if (op < 40) begin
        d = {3'($urandom), 1'b1, 4'($urandom)};
        do_cycle("rnd_icw1", 1, 0, 0, d);
      end else if (op < 75) begin
        do_cycle("rnd_a0", 0, 1, 0, 8'($urandom));
      end else if (op < 95) begin
        d = {1'b0, 2'($urandom), 2'b01, 3'($urandom)};
        do_cycle("rnd_ocw3", 0, 0, 1, d);
      end else if (op < 98) begin
        d = {3'($urandom), 1'b1, 4'($urandom)};
        do_cycle("rnd_icw1_ocw3", 1, 0, 1, d);
      end else begin
        do_reset("rnd_rst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
